// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
//   state_t      : arbiter FSM states
//   lsb_size_t   : load/store access size codes
//   req_id_t     : requester identity, used to remember the last grant
//   IO_UART_ADDR : UART data register; stores to it stall while the UART buffer is full
//   size_bytes() : access size code -> byte count (code 3 behaves as a word)
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_LSB_RD,
        ST_LSB_WR,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_BAD = 2'd3
    } lsb_size_t;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSB = 1'b1
    } req_id_t;

    localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (lsb_size_t'(size))
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Byte-beat sequencer for the single byte-serial RAM port.
// Owns the RAM address register, the beat counter and the read-capture shift
// register. A transaction is loaded with start; each step advances one beat.
//   clk_in, rst_in   : clock, synchronous active-high reset
//   en               : global enable; low freezes everything
//   start            : load start_addr / start_count, clear beat and line
//   step             : advance one beat (asserted while a transfer is active)
//   rd_mode          : current transfer is a read, so capture mem_din
//   mem_din          : RAM read byte
//   addr             : RAM address (drives mem_a)
//   count            : bytes in the current transfer
//   next_idx         : index of the byte to drive on the next write beat
//   rd_final         : this edge captures the last read byte
//   wr_final         : the last write byte is on the bus this cycle
//   line_nxt         : shift register value including the byte on mem_din now
module mem_beat_seq #(
    parameter int LINE_BYTES = 16,
    parameter int CNT_W      = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    en,
    input  logic                    start,
    input  logic [31:0]             start_addr,
    input  logic [CNT_W-1:0]        start_count,
    input  logic                    step,
    input  logic                    rd_mode,
    input  logic [7:0]              mem_din,
    output logic [31:0]             addr,
    output logic [CNT_W-1:0]        count,
    output logic [1:0]              next_idx,
    output logic                    rd_final,
    output logic                    wr_final,
    output logic [8*LINE_BYTES-1:0] line_nxt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0]        beat;
    logic [8*LINE_BYTES-1:0] line;

    // Bytes shift in from the top, so after N captures byte 0 sits lowest
    // among the N most-significant bytes.
    assign line_nxt = {mem_din, line[8*LINE_BYTES-1:8]};

    // The RAM answers one cycle after it sees an address, so a read needs
    // one beat more than it has bytes; a write finishes on its last byte.
    assign rd_final = (beat == count);
    assign wr_final = (beat == count - ONE);
    assign next_idx = beat[1:0] + 2'd1;

    // NOTE: sequential state is updated only with non-blocking (<=) so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr  <= '0;
            beat  <= '0;
            count <= '0;
            line  <= '0;
        end else if (en) begin
            if (start) begin
                addr  <= start_addr;
                beat  <= '0;
                count <= start_count;
                line  <= '0;
            end else if (step) begin
                beat <= beat + ONE;
                if (beat + ONE < count) begin
                    addr <= addr + 32'd1;
                end
                // Beat 0 has no data yet: the RAM is still reading byte 0.
                if (rd_mode && beat != '0) begin
                    line <= line_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single byte-serial RAM port, shared by the instruction-fetch
// line refill (read only, LINE_BYTES bytes) and the load/store buffer
// (1/2/4-byte load or store). Ties alternate; the IF side wins the first one.
//   clk_in, rst_in, rdy_in : clock, synchronous active-high reset, global enable
//   clear                  : pipeline flush; aborts reads, never stores
//   io_buffer_full         : UART full; stalls LSB accesses to IO_UART_ADDR
//   if_req/if_addr         : line refill request (held until if_done)
//   if_done/if_data        : one-cycle done pulse and the assembled line
//   lsb_req/wr/size/addr/wdata : load/store request (held until lsb_done)
//   lsb_done/lsb_rdata     : one-cycle done pulse and zero-extended load data
//   mem_din/mem_dout/mem_a/mem_wr : RAM port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int LINE_WIDTH = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    clear,
    input  logic                    io_buffer_full,
    input  logic                    if_req,
    input  logic [31:0]             if_addr,
    output logic                    if_done,
    output logic [8*LINE_BYTES-1:0] if_data,
    input  logic                    lsb_req,
    input  logic                    lsb_wr,
    input  logic [1:0]              lsb_size,
    input  logic [31:0]             lsb_addr,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr
);

    localparam int CNT_W = LINE_WIDTH + 1;

    state_t  state, state_nxt;
    req_id_t last_grant;

    logic                    lsb_ok;
    logic                    grant_if, grant_lsb;
    logic                    seq_start, seq_step, finish;
    logic [31:0]             start_addr;
    logic [CNT_W-1:0]        start_count;
    logic [CNT_W-1:0]        count;
    logic [1:0]              next_idx;
    logic                    rd_final, wr_final;
    logic                    rd_mode;
    logic [8*LINE_BYTES-1:0] line_nxt;
    logic [31:0]             top_word, lsb_word;
    logic                    if_done_r, lsb_done_r, done_rd;

    assign lsb_ok  = lsb_req && !(io_buffer_full && lsb_addr == IO_UART_ADDR);
    assign rd_mode = (state == ST_IF_RD) || (state == ST_LSB_RD);

    mem_beat_seq #(
        .LINE_BYTES(LINE_BYTES),
        .CNT_W     (CNT_W)
    ) u_seq (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .en         (rdy_in),
        .start      (seq_start),
        .start_addr (start_addr),
        .start_count(start_count),
        .step       (seq_step),
        .rd_mode    (rd_mode),
        .mem_din    (mem_din),
        .addr       (mem_a),
        .count      (count),
        .next_idx   (next_idx),
        .rd_final   (rd_final),
        .wr_final   (wr_final),
        .line_nxt   (line_nxt)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        grant_if    = 1'b0;
        grant_lsb   = 1'b0;
        seq_start   = 1'b0;
        seq_step    = 1'b0;
        finish      = 1'b0;
        start_addr  = if_addr;
        start_count = CNT_W'(LINE_BYTES);
        case (state)
            ST_IDLE: begin
                if (if_req && (!lsb_ok || last_grant == REQ_LSB)) begin
                    grant_if  = 1'b1;
                    seq_start = 1'b1;
                    state_nxt = ST_IF_RD;
                end else if (lsb_ok) begin
                    grant_lsb   = 1'b1;
                    seq_start   = 1'b1;
                    start_addr  = lsb_addr;
                    start_count = CNT_W'(size_bytes(lsb_size));
                    state_nxt   = lsb_wr ? ST_LSB_WR : ST_LSB_RD;
                end
            end
            ST_IF_RD, ST_LSB_RD: begin
                if (clear) begin
                    state_nxt = ST_IDLE;
                end else begin
                    seq_step = 1'b1;
                    if (rd_final) begin
                        finish    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            // Committed stores run to completion regardless of clear.
            ST_LSB_WR: begin
                seq_step = 1'b1;
                if (wr_final) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Load data: the N bytes just assembled are the top N bytes of the line;
    // move them to the bottom and zero the rest.
    always_comb begin
        top_word = line_nxt[8*LINE_BYTES-1 -: 32];
        lsb_word = top_word;
        if (count == CNT_W'(1)) begin
            lsb_word = {24'd0, top_word[31:24]};
        end else if (count == CNT_W'(2)) begin
            lsb_word = {16'd0, top_word[31:16]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant <= REQ_LSB;
            mem_wr     <= 1'b0;
            mem_dout   <= 8'd0;
            if_done_r  <= 1'b0;
            lsb_done_r <= 1'b0;
            done_rd    <= 1'b0;
            if_data    <= '0;
            lsb_rdata  <= 32'd0;
        end else if (rdy_in) begin
            if_done_r  <= 1'b0;
            lsb_done_r <= 1'b0;
            if (grant_if) begin
                last_grant <= REQ_IF;
            end
            if (grant_lsb) begin
                last_grant <= REQ_LSB;
                if (lsb_wr) begin
                    mem_wr   <= 1'b1;
                    mem_dout <= lsb_wdata[7:0];
                end
            end
            if (state == ST_LSB_WR) begin
                if (wr_final) begin
                    mem_wr <= 1'b0;
                end else begin
                    mem_dout <= lsb_wdata[{next_idx, 3'b000} +: 8];
                end
            end
            if (finish) begin
                done_rd <= (state != ST_LSB_WR);
                if (state == ST_IF_RD) begin
                    if_done_r <= 1'b1;
                    if_data   <= line_nxt;
                end else begin
                    lsb_done_r <= 1'b1;
                    if (state == ST_LSB_RD) begin
                        lsb_rdata <= lsb_word;
                    end
                end
            end
        end
    end

    // A flush arriving in the DONE cycle of a read cancels the pending pulse;
    // a store's done is never cancelled. if_done only ever comes from a read.
    assign if_done  = if_done_r && !(clear && rdy_in);
    assign lsb_done = lsb_done_r && !(clear && rdy_in && done_rd);

endmodule
